// File: rtl/amm_traffic_sched.sv
// Avalon-MM traffic sequencer: write bursts, then read bursts (or either alone),
// with read bursts in flight capped at MAX_OUTST and a completion handshake to the measurement block.
module amm_traffic_sched #(
    parameter int ADDR_W      = 32,
    parameter int AMM_BURST_W = 11,
    parameter int DATA_B_W    = 64,
    parameter int MAX_OUTST   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    test_start_i,
    input  logic [1:0]              cfg_mode_i,
    input  logic [ADDR_W-1:0]       cfg_base_addr_i,
    input  logic [AMM_BURST_W-1:0]  cfg_burst_len_i,
    input  logic [15:0]             cfg_trans_cnt_i,
    input  logic                    meas_busy_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    meas_start_o,
    output logic [ADDR_W-1:0]       address_o,
    output logic                    read_o,
    output logic                    write_o,
    output logic [AMM_BURST_W-1:0]  burstcount_o,
    output logic [DATA_B_W-1:0]     byteenable_o,
    output logic [8*DATA_B_W-1:0]   writedata_o,
    input  logic                    waitrequest_i,
    input  logic                    readdatavalid_i
);

    localparam int OUT_W = $clog2(MAX_OUTST) + 1;
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RD_DRAIN,
        S_MEAS_WAIT
    } state_t;

    state_t                 state;
    logic [1:0]             mode_r;
    logic [ADDR_W-1:0]      base_r;
    logic [AMM_BURST_W-1:0] len_r;
    logic [15:0]            cnt_r;
    logic [AMM_BURST_W-1:0] beat_cnt;
    logic [15:0]            burst_cnt;
    logic [31:0]            beat_idx;
    logic [AMM_BURST_W-1:0] rd_beat;
    logic [OUT_W-1:0]       outst;
    logic [OUT_W-1:0]       outst_nxt;
    logic                   wait_done;

    logic                   wr_acc;
    logic                   rd_acc;
    logic                   rd_cmp;
    logic                   last_burst;
    logic [AMM_BURST_W-1:0] len_m1;
    logic [ADDR_W-1:0]      len_addr;

    assign wr_acc     = write_o && !waitrequest_i;
    assign rd_acc     = read_o && !waitrequest_i;
    assign len_m1     = len_r - AMM_BURST_W'(1);
    assign len_addr   = ADDR_W'(len_r);
    assign last_burst = (burst_cnt == cnt_r - 16'd1);
    // Beats arriving with nothing in flight are stray and must not advance rd_beat.
    assign rd_cmp     = readdatavalid_i && (outst != '0) && (rd_beat == len_m1);

    always_comb begin
        outst_nxt = outst;
        if (rd_acc && !rd_cmp) begin
            outst_nxt = outst + OUT_W'(1);
        end else if (!rd_acc && rd_cmp) begin
            outst_nxt = outst - OUT_W'(1);
        end
    end

    assign meas_start_o = !rst_i && (state == S_IDLE) && test_start_i;
    assign byteenable_o = '1;
    assign writedata_o  = {(DATA_B_W/4){beat_idx}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            read_o       <= 1'b0;
            write_o      <= 1'b0;
            address_o    <= '0;
            burstcount_o <= '0;
            beat_cnt     <= '0;
            burst_cnt    <= '0;
            beat_idx     <= '0;
            rd_beat      <= '0;
            outst        <= '0;
            wait_done    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            outst  <= outst_nxt;
            if (readdatavalid_i && (outst != '0)) begin
                rd_beat <= (rd_beat == len_m1) ? '0 : rd_beat + AMM_BURST_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (test_start_i) begin
                        mode_r       <= cfg_mode_i;
                        base_r       <= cfg_base_addr_i;
                        len_r        <= cfg_burst_len_i;
                        cnt_r        <= cfg_trans_cnt_i;
                        address_o    <= cfg_base_addr_i;
                        burstcount_o <= cfg_burst_len_i;
                        beat_cnt     <= '0;
                        burst_cnt    <= '0;
                        beat_idx     <= '0;
                        wait_done    <= 1'b0;
                        busy_o       <= 1'b1;
                        if ((cfg_burst_len_i == '0) || (cfg_trans_cnt_i == '0)) begin
                            state <= S_MEAS_WAIT;
                        end else if (cfg_mode_i == 2'd1) begin
                            state  <= S_RD;
                            read_o <= 1'b1;
                        end else begin
                            state   <= S_WR;
                            write_o <= 1'b1;
                        end
                    end
                end

                S_WR: begin
                    if (wr_acc) begin
                        beat_idx <= beat_idx + 32'd1;
                        if (beat_cnt == len_m1) begin
                            beat_cnt  <= '0;
                            burst_cnt <= burst_cnt + 16'd1;
                            address_o <= address_o + len_addr;
                            if (last_burst) begin
                                write_o   <= 1'b0;
                                burst_cnt <= '0;
                                if (mode_r == 2'd0) begin
                                    state     <= S_MEAS_WAIT;
                                    wait_done <= 1'b0;
                                end else begin
                                    address_o <= base_r;
                                    state     <= S_RD;
                                    read_o    <= 1'b1;
                                end
                            end
                        end else begin
                            beat_cnt <= beat_cnt + AMM_BURST_W'(1);
                        end
                    end
                end

                S_RD: begin
                    if (rd_acc) begin
                        address_o <= address_o + len_addr;
                        burst_cnt <= burst_cnt + 16'd1;
                    end
                    // A pending request stays up under waitrequest regardless of outst.
                    if (rd_acc && last_burst) begin
                        read_o    <= 1'b0;
                        burst_cnt <= '0;
                        state     <= S_RD_DRAIN;
                    end else if (!read_o || rd_acc) begin
                        read_o <= (outst_nxt < OUT_MAX);
                    end
                end

                S_RD_DRAIN: begin
                    if (outst == '0) begin
                        state     <= S_MEAS_WAIT;
                        wait_done <= 1'b0;
                    end
                end

                S_MEAS_WAIT: begin
                    // Two cycles minimum covers the measurement block's delay-save pipeline.
                    if (!wait_done) begin
                        wait_done <= 1'b1;
                    end else if (!meas_busy_i) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amm_traffic_sched.sv
// Scoreboard bench for amm_traffic_sched: directed tests push expected Avalon
// transactions into queues; a negedge monitor pops and compares them as the DUT issues them.
module tb_amm_traffic_sched;

    localparam int ADDR_W = 32;
    localparam int BW     = 11;
    localparam int DB     = 64;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              test_start_i = 1'b0;
    logic [1:0]        cfg_mode_i = '0;
    logic [ADDR_W-1:0] cfg_base_addr_i = '0;
    logic [BW-1:0]     cfg_burst_len_i = '0;
    logic [15:0]       cfg_trans_cnt_i = '0;
    logic              meas_busy_i = 1'b0;
    logic              waitrequest_i = 1'b0;
    logic              readdatavalid_i = 1'b0;
    logic              busy_o, done_o, meas_start_o, read_o, write_o;
    logic [ADDR_W-1:0] address_o;
    logic [BW-1:0]     burstcount_o;
    logic [DB-1:0]     byteenable_o;
    logic [8*DB-1:0]   writedata_o;

    amm_traffic_sched dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .test_start_i    (test_start_i),
        .cfg_mode_i      (cfg_mode_i),
        .cfg_base_addr_i (cfg_base_addr_i),
        .cfg_burst_len_i (cfg_burst_len_i),
        .cfg_trans_cnt_i (cfg_trans_cnt_i),
        .meas_busy_i     (meas_busy_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .meas_start_o    (meas_start_o),
        .address_o       (address_o),
        .read_o          (read_o),
        .write_o         (write_o),
        .burstcount_o    (burstcount_o),
        .byteenable_o    (byteenable_o),
        .writedata_o     (writedata_o),
        .waitrequest_i   (waitrequest_i),
        .readdatavalid_i (readdatavalid_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] idx;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [31:0] rd_q[$];
    int          resp_due[$];

    int cyc = 0;
    int pass_cnt = 0;
    int chk_cnt = 0;
    int tb_len = 1;
    int lat = 20;
    int wr_cnt = 0, first_wr_cyc = 0, last_wr_cyc = 0;
    int rd_acc_cnt = 0, rdv_cnt = 0, last_rdv_cyc = 0;
    int bench_outst = 0, peak = 0, beat_b = 0;
    int ms_cnt = 0, done_cnt = 0, done_cyc = 0;
    int hold_seen = 0;
    logic        prev_rd_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        wr_exp_t     e;
        logic [31:0] ea;
        if (rst_i) begin
            bench_outst = 0;
            beat_b = 0;
        end else begin
            if (prev_rd_wait) begin
                chk("rd_hold", read_o, 1);
                chk("rd_addr_hold", address_o, prev_addr);
            end
            if (read_o && waitrequest_i) hold_seen++;
            if (write_o && !waitrequest_i) begin
                if (wr_cnt == 0) first_wr_cyc = cyc;
                wr_cnt++;
                last_wr_cyc = cyc;
                if (wr_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL wr_unexpected: write at %0h, none expected", address_o);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", address_o, e.addr);
                    chk("wr_data", writedata_o, {16{e.idx}});
                    chk("wr_len", burstcount_o, tb_len);
                end
            end
            if (readdatavalid_i && bench_outst > 0) begin
                rdv_cnt++;
                last_rdv_cyc = cyc;
                beat_b++;
                if (beat_b == tb_len) begin
                    beat_b = 0;
                    bench_outst--;
                end
            end
            if (read_o && !waitrequest_i) begin
                rd_acc_cnt++;
                bench_outst++;
                resp_due.push_back(cyc + lat);
                if (rd_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL rd_unexpected: read at %0h, none expected", address_o);
                end else begin
                    ea = rd_q.pop_front();
                    chk("rd_addr", address_o, ea);
                    chk("rd_len", burstcount_o, tb_len);
                end
            end
            if (bench_outst > peak) peak = bench_outst;
            if (meas_start_o) ms_cnt++;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_busy_low", busy_o, 0);
            end
        end
        prev_rd_wait = !rst_i && read_o && waitrequest_i;
        prev_addr = address_o;
    end

    // Memory read responder: tb_len beats per burst, lat cycles after accept
    always begin
        int rem;
        @(posedge clk);
        #1;
        if (rst_i) begin
            rem = 0;
            resp_due.delete();
            readdatavalid_i = 1'b0;
        end else begin
            if (rem == 0 && resp_due.size() > 0 && cyc >= resp_due[0]) begin
                void'(resp_due.pop_front());
                rem = tb_len;
            end
            if (rem > 0) begin
                readdatavalid_i = 1'b1;
                rem--;
            end else begin
                readdatavalid_i = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_test(input logic [1:0] mode, input logic [31:0] base,
                              input int len, input int cnt);
        tick();
        tb_len = len;
        cfg_mode_i = mode;
        cfg_base_addr_i = base;
        cfg_burst_len_i = BW'(len);
        cfg_trans_cnt_i = 16'(cnt);
        test_start_i = 1'b1;
        @(negedge clk);
        chk("meas_start_pulse", meas_start_o, 1);
        tick();
        test_start_i = 1'b0;
        @(negedge clk);
        chk("busy_set", busy_o, 1);
    endtask

    task automatic wait_done(input int exp_done, input int max_cyc);
        int n = 0;
        while (done_cnt < exp_done && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        chk("done_count", done_cnt, exp_done);
    endtask

    initial begin
        int ms0, d0, fall_cyc, n;
        #20000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int ms0, d0, fall_cyc, n;
        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_meas_start", meas_start_o, 0);
        chk("rst_read", read_o, 0);
        chk("rst_write", write_o, 0);
        chk("rst_addr", address_o, 0);
        chk("rst_burstcount", burstcount_o, 0);
        chk("byteenable", byteenable_o, {DB{1'b1}});
        tick();
        rst_i = 1'b0;

        // T1: write only, base 0x100, len 4, cnt 3
        for (int i = 0; i < 12; i++) wr_q.push_back('{32'h100 + 32'(4 * (i / 4)), 32'(i)});
        wr_cnt = 0;
        ms0 = ms_cnt;
        start_test(2'd0, 32'h100, 4, 3);
        wait_done(1, 200);
        chk("t1_beats", wr_cnt, 12);
        chk("t1_back_to_back", last_wr_cyc - first_wr_cyc, 11);
        // done rises on the second edge after the edge that took the last beat
        chk("t1_done_lat", done_cyc - last_wr_cyc, 3);
        chk("t1_wr_q_empty", wr_q.size(), 0);
        chk("t1_one_meas_start", ms_cnt - ms0, 1);
        @(negedge clk);
        chk("t1_done_one_cycle", done_o, 0);
        chk("t1_busy_clear", busy_o, 0);

        // T2: read only, len 2, cnt 8, latency 20
        lat = 20;
        for (int i = 0; i < 8; i++) rd_q.push_back(32'h200 + 32'(2 * i));
        peak = 0; rdv_cnt = 0; rd_acc_cnt = 0;
        start_test(2'd1, 32'h200, 2, 8);
        wait_done(2, 600);
        chk("t2_peak_outst", peak, 4);
        chk("t2_requests", rd_acc_cnt, 8);
        chk("t2_rdv_beats", rdv_cnt, 16);
        chk("t2_done_after_drain", (done_cyc - last_rdv_cyc) >= 3, 1);
        chk("t2_rd_q_empty", rd_q.size(), 0);

        // T3: waitrequest held 5 cycles with 3 reads in flight
        for (int i = 0; i < 5; i++) rd_q.push_back(32'h300 + 32'(2 * i));
        rd_acc_cnt = 0; rdv_cnt = 0; hold_seen = 0;
        start_test(2'd1, 32'h300, 2, 5);
        n = 0;
        while (rd_acc_cnt < 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        waitrequest_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        waitrequest_i = 1'b0;
        wait_done(3, 600);
        chk("t3_hold_cycles", hold_seen, 5);
        chk("t3_requests", rd_acc_cnt, 5);
        chk("t3_rdv_beats", rdv_cnt, 10);
        chk("t3_rd_q_empty", rd_q.size(), 0);

        // T4: mode 2, len 1, cnt 2, meas_busy high 10 cycles after drain
        lat = 3;
        meas_busy_i = 1'b1;
        wr_q.push_back('{32'h400, 32'd0});
        wr_q.push_back('{32'h401, 32'd1});
        rd_q.push_back(32'h400);
        rd_q.push_back(32'h401);
        rdv_cnt = 0;
        ms0 = ms_cnt;
        start_test(2'd2, 32'h400, 1, 2);
        tick();
        test_start_i = 1'b1;
        tick();
        test_start_i = 1'b0;
        n = 0;
        while (rdv_cnt < 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (10) tick();
        chk("t4_no_done_while_meas_busy", done_cnt, 3);
        meas_busy_i = 1'b0;
        fall_cyc = cyc;
        wait_done(4, 100);
        chk("t4_done_after_fall", done_cyc > fall_cyc, 1);
        chk("t4_no_second_meas_start", ms_cnt - ms0, 1);
        chk("t4_queues_empty", wr_q.size() + rd_q.size(), 0);

        // T5: reset during beat 2 of 4, then restart
        wr_q.push_back('{32'h40, 32'd0});
        wr_q.push_back('{32'h40, 32'd1});
        wr_cnt = 0;
        start_test(2'd0, 32'h40, 4, 2);
        n = 0;
        while (wr_cnt < 2 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        chk("t5_write_dropped", write_o, 0);
        chk("t5_busy_dropped", busy_o, 0);
        chk("t5_beats_before_rst", wr_cnt, 2);
        for (int i = 0; i < 4; i++) wr_q.push_back('{32'h40, 32'(i)});
        d0 = done_cnt;
        start_test(2'd0, 32'h40, 4, 1);
        wait_done(d0 + 1, 100);
        chk("t5_restart_beats", wr_cnt, 6);
        chk("t5_wr_q_empty", wr_q.size(), 0);

        // T6: cnt = 0 goes straight to the measurement wait
        meas_busy_i = 1'b1;
        ms0 = ms_cnt;
        d0 = done_cnt;
        wr_cnt = 0; rd_acc_cnt = 0;
        start_test(2'd2, 32'h500, 4, 0);
        repeat (5) tick();
        chk("t6_no_done_while_meas_busy", done_cnt, d0);
        meas_busy_i = 1'b0;
        wait_done(d0 + 1, 50);
        chk("t6_meas_start", ms_cnt - ms0, 1);
        chk("t6_no_traffic", wr_cnt + rd_acc_cnt, 0);
        repeat (3) tick();
        chk("t6_single_done", done_cnt, d0 + 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
